alu_mc: RTL
===========

# alu_mc

Parametrised multi-cycle ALU: the sequential successor to the 32-bit combinational ALU. It supports configurable operand width, a valid/ready handshake on input and output, and a registered result. Status flags are optional. Division runs on an iterative restoring divider with remainder, not a combinational divide. The block sits between the operand-fetch stage and the writeback stage of the datapath.

## Interface
- `W`, default 32: operand and result width; legal values are 8 to 64.
- `clk`  in  1: clock; all logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: an operation is presented.
- `in_ready`  out  1: the block can accept an operation.
- `a`, `b`  in  W: operands.
- `sel`  in  3: opcode; same encoding as the existing ALU (000 NOT, 001 OR, 010 AND, 011 NEG, 100 ADD, 101 SUB, 110 MUL, 111 DIV).
- `out_valid`  out  1: the result is valid.
- `out_ready`  in  1: downstream accepts the result.
- `result`  out  W: primary result. For DIV this is the quotient.
- `rem`  out  W: remainder for DIV; 0 for every other op.
- `flags`  out  5: {dz, v, c, n, z}.

## Operation
- State machine:
  - IDLE → BUSY on acceptance of a DIV with `b` ≠ 0.
  - IDLE → DONE on acceptance of any other op, or of a DIV with `b` = 0.
  - BUSY → DONE after W iterations.
  - DONE → IDLE on `out_ready`, or DONE → DONE if a new non-DIV op (or DIV with `b` = 0) is accepted in the same cycle.
  - DONE → BUSY if a DIV with `b` ≠ 0 is accepted in the same cycle as `out_ready`.
- `in_ready` = (state==IDLE) or (state==DONE and `out_ready`); it is 0 while `rst` is high.
- Acceptance happens when `in_valid` and `in_ready` are both high. `a`, `b` and `sel` are captured at that point; later input changes have no effect.
- `out_valid` = (state==DONE). `result`, `rem` and `flags` stay stable while `out_valid` is high and `out_ready` is low.
- All arithmetic is modulo 2^W.
  - MUL returns the low W bits of the product.
  - NEG is 0 − a.
- DIV is unsigned.
  - With `b` = 0: quotient 0, remainder = `a`, dz = 1.
- Flags:
  - z: `result` == 0.
  - n: `result`[W−1].
  - c: carry-out for ADD; borrow for SUB and NEG; upper W product bits nonzero for MUL; 0 otherwise.
  - v: signed overflow for ADD, SUB and NEG; 0 otherwise.
  - dz: set only for DIV by zero.
- Reset values: state IDLE; `out_valid`, `result`, `rem` and `flags` all 0.
- Reset in the middle of an operation abandons it. Nothing is emitted and no partial result appears.

## Timing
- Non-DIV ops and DIV by zero: accepted in cycle N, `out_valid` high in cycle N+1.
- DIV with `b` ≠ 0: accepted in cycle N, `out_valid` high in cycle N+W+1.
- Sustained throughput is one non-DIV op per cycle when `out_ready` is held high.
- `in_ready` is combinational from state and `out_ready`. No combinational path runs from `in_valid` to `out_valid`.

## Configuration
- `ALU_MC_FLAGS_EN` defined: the flag logic is built as described above.
- `ALU_MC_FLAGS_EN` undefined: `flags` is tied to 0 and the flag logic is removed. DIV by zero still returns quotient 0 and remainder `a`.

## Structure
- Package `alu_mc_pkg` holds:
  - the opcode enum `alu_op_e`, matching the 3-bit encodings;
  - the state enum `alu_state_e` (IDLE, BUSY, DONE);
  - the flag bit-index constants.
- Sub-module `alu_div_iter` is a restoring divider.
  - Ports: start, a, b, busy, done, quotient, remainder; parameter W.
  - One quotient bit per cycle.
  - It aborts on `rst`.

## Test plan
- W=32, ADD with a=0xFFFF_FFFF, b=1, `out_ready` held high → result 0, z=1, c=1, v=0, `out_valid` exactly one cycle after acceptance.
- W=32, SUB with a=0x8000_0000, b=1 → result 0x7FFF_FFFF, v=1, c=0, n=0.
- W=32, DIV with a=100, b=7 → `out_valid` 33 cycles after acceptance, quotient 14, rem 2, `in_ready` low throughout BUSY.
- W=8, DIV with a=0x55, b=0 → result 0, rem 0x55, dz=1, one-cycle latency.
- Backpressure: MUL with a=0x1_0000, b=0x1_0000, `out_ready` held low for 5 cycles → result 0 and c=1 held stable for the 5 cycles, `in_ready` low; then `out_ready`=1 together with a new AND is accepted in the same cycle.
- Assert `rst` 10 cycles into a W=32 DIV → no `out_valid`; `in_ready` returns high in the cycle after `rst` is released; a following OR with a=0xF0, b=0x0F returns 0xFF.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// Shared types for the multi-cycle ALU: opcode and state encodings, flag bit positions.
package alu_mc_pkg;

  typedef enum logic [2:0] {
    OP_NOT = 3'b000,
    OP_OR  = 3'b001,
    OP_AND = 3'b010,
    OP_NEG = 3'b011,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101,
    OP_MUL = 3'b110,
    OP_DIV = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  localparam int FLAG_Z  = 0;
  localparam int FLAG_N  = 1;
  localparam int FLAG_C  = 2;
  localparam int FLAG_V  = 3;
  localparam int FLAG_DZ = 4;
  localparam int FLAG_W  = 5;

endpackage

// File: rtl/alu_mc_div.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, W cycles per divide.
// done is high during the final iteration, so quotient/remainder are final on the next cycle.
module alu_div_iter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int CW = $clog2(W + 1);

  logic [CW-1:0] cnt;
  logic [W-1:0]  dvs;
  logic [W:0]    trial;
  logic [W-1:0]  quo_nx;
  logic [W-1:0]  rmd_nx;

  // Partial remainder is always below the divisor, so W+1 bits hold the trial difference.
  always_comb begin
    trial = {remainder, quotient[W-1]} - {1'b0, dvs};
    if (!trial[W]) begin
      rmd_nx = trial[W-1:0];
      quo_nx = {quotient[W-2:0], 1'b1};
    end else begin
      rmd_nx = {remainder[W-2:0], quotient[W-1]};
      quo_nx = {quotient[W-2:0], 1'b0};
    end
  end

  assign done = busy && (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      cnt       <= '0;
      dvs       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (start) begin
      busy      <= 1'b1;
      cnt       <= CW'(W);
      dvs       <= b;
      quotient  <= a;
      remainder <= '0;
    end else if (busy) begin
      quotient  <= quo_nx;
      remainder <= rmd_nx;
      cnt       <= cnt - CW'(1);
      if (cnt == CW'(1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshake and registered result; DIV uses alu_div_iter.
// Define ALU_MC_FLAGS_EN to build the {dz, v, c, n, z} flag logic; otherwise flags reads 0.
//
// state | meaning
// IDLE  | no result held, ready for an operation
// BUSY  | iterative divide in progress, input blocked
// DONE  | result presented on out_valid until out_ready
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   sel,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [W-1:0] rem,
  output logic [4:0]   flags
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_BUSY = ST_BUSY;
  localparam logic [1:0] S_DONE = ST_DONE;

  logic [1:0]   state;
  alu_op_e      op;
  logic         accept;
  logic         div_start;
  logic         div_busy;
  logic         div_done;
  logic         is_div_r;
  logic [W-1:0] div_q;
  logic [W-1:0] div_rem;
  logic [W-1:0] res_c;
  logic [W-1:0] rem_c;
  logic [W-1:0] res_r;
  logic [W-1:0] rem_r;

  assign op        = alu_op_e'(sel);
  assign in_ready  = !rst && ((state == S_IDLE) || ((state == S_DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign div_start = accept && (op == OP_DIV) && (b != '0);
  assign out_valid = (state == S_DONE);

  always_comb begin
    res_c = '0;
    rem_c = '0;
    case (op)
      OP_NOT: res_c = ~a;
      OP_OR:  res_c = a | b;
      OP_AND: res_c = a & b;
      OP_NEG: res_c = '0 - a;
      OP_ADD: res_c = a + b;
      OP_SUB: res_c = a - b;
      OP_MUL: res_c = a * b;
      // only reached for a zero divisor; nonzero divisors go to the iterative divider
      OP_DIV: rem_c = a;
      default: res_c = '0;
    endcase
  end

  alu_div_iter #(.W(W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .a         (a),
    .b         (b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_rem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      res_r    <= '0;
      rem_r    <= '0;
      is_div_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            is_div_r <= 1'b0;
            if (div_start) begin
              state <= S_BUSY;
            end else begin
              state <= S_DONE;
              res_r <= res_c;
              rem_r <= rem_c;
            end
          end else if ((state == S_DONE) && out_ready) begin
            state <= S_IDLE;
          end
        end
        S_BUSY: begin
          if (div_done) begin
            state    <= S_DONE;
            is_div_r <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Divider registers hold their final values until the next start, so they feed the outputs directly.
  assign result = is_div_r ? div_q   : res_r;
  assign rem    = is_div_r ? div_rem : rem_r;

`ifdef ALU_MC_FLAGS_EN
  logic [2*W-1:0]    prod_full;
  logic [FLAG_W-1:0] flags_c;
  logic [FLAG_W-1:0] flags_r;
  logic [FLAG_W-1:0] div_flags;

  assign prod_full = {{W{1'b0}}, a} * {{W{1'b0}}, b};

  always_comb begin
    flags_c         = '0;
    flags_c[FLAG_Z] = (res_c == '0);
    flags_c[FLAG_N] = res_c[W-1];
    case (op)
      OP_ADD: begin
        flags_c[FLAG_C] = (res_c < a);
        flags_c[FLAG_V] = (a[W-1] == b[W-1]) && (res_c[W-1] != a[W-1]);
      end
      OP_SUB: begin
        flags_c[FLAG_C] = (a < b);
        flags_c[FLAG_V] = (a[W-1] != b[W-1]) && (res_c[W-1] != a[W-1]);
      end
      OP_NEG: begin
        flags_c[FLAG_C] = (a != '0);
        flags_c[FLAG_V] = a[W-1] && res_c[W-1];
      end
      OP_MUL:  flags_c[FLAG_C]  = ((prod_full >> W) != '0);
      OP_DIV:  flags_c[FLAG_DZ] = 1'b1;
      default: flags_c[FLAG_C]  = 1'b0;
    endcase
  end

  always_comb begin
    div_flags         = '0;
    div_flags[FLAG_Z] = (div_q == '0);
    div_flags[FLAG_N] = div_q[W-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_r <= '0;
    end else if (accept && !div_start) begin
      flags_r <= flags_c;
    end
  end

  assign flags = is_div_r ? div_flags : flags_r;
`else
  assign flags = '0;
`endif

endmodule
